mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multicycle control FSM for the MIPS-subset CPU. Sequences the instruction-fetch unit (`write_pc`, `is_branch`, `is_jump`), the instruction register, register file, ALU and data memory so that each instruction takes 2–5 cycles instead of one. Sits between the decoded instruction-register fields and every datapath enable, with ready handshakes to both memories.

## Interface
- No parameters; opcode, funct and ALU codes are package constants.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; forces state FETCH.
- `opcode` in 6: IR[31:26], stable from DECODE to end of instruction.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag, valid in BRANCH.
- `imem_ready` in 1: instruction word valid this cycle.
- `dmem_ready` in 1: data access completes this cycle.
- `imem_req` out 1: instruction fetch request.
- `ir_write` out 1: latch instruction register.
- `write_pc` out 1: PC update strobe to ifetch.
- `is_branch` out 1: ifetch takes PC+4+offset.
- `is_jump` out 1: ifetch takes {PC[31:28], target, 2'b00}.
- `pc_from_reg` out 1: PC loads rs (JR).
- `reg_write` out 1: register file write enable.
- `reg_dst` out 2: 0=rt, 1=rd, 2=r31.
- `wb_sel` out 2: 0=ALU, 1=memory, 2=PC+4.
- `alu_src` out 1: 0=rt, 1=sign-extended immediate.
- `alu_op` out 2: 0=ADD, 1=SUB, 2=XOR, 3=SLT.
- `dmem_read`, `dmem_write` out 1 each: data memory strobes.
- `halted` out 1: sticky illegal-instruction flag.
- `retired` out 32: instructions retired since reset.

## Operation
- States: FETCH, DECODE, EXEC, ALUWB, MEMADDR, MEMRD, MEMWB, MEMWR, BRANCH, LINK, JREG, TRAP.
- FETCH: `imem_req`=1; on `imem_ready` assert `ir_write`, go DECODE; else hold.
- DECODE: J (0x02) → `write_pc`,`is_jump` → FETCH. JAL (0x03) → LINK. BNE (0x05) → BRANCH. LW (0x23)/SW (0x2B) → MEMADDR. ADDI (0x08), XORI (0x0E), R-type (0x00) with funct ADD 0x20/SUB 0x22/SLT 0x2A → EXEC. R-type funct JR 0x08 → JREG. Anything else → TRAP.
- EXEC: `alu_src`=1 for ADDI/XORI; `alu_op` from opcode/funct → ALUWB.
- ALUWB: `reg_write`, `reg_dst`=1 for R-type else 0, `wb_sel`=0, `write_pc` → FETCH.
- MEMADDR: `alu_src`=1, `alu_op`=ADD → MEMRD (LW) or MEMWR (SW).
- MEMRD: `dmem_read` held until `dmem_ready`, then MEMWB. MEMWB: `reg_write`, `reg_dst`=0, `wb_sel`=1, `write_pc` → FETCH.
- MEMWR: `dmem_write` held until `dmem_ready`; in that cycle `write_pc` → FETCH.
- BRANCH: `alu_op`=SUB, `write_pc`=1, `is_branch`=!`zero` → FETCH.
- LINK: `reg_write`, `reg_dst`=2, `wb_sel`=2, `write_pc`, `is_jump` → FETCH.
- JREG: `write_pc`, `pc_from_reg` → FETCH.
- TRAP: all strobes 0, `halted`=1; stays until reset.
- `retired` increments on every `write_pc` cycle; wraps 0xFFFFFFFF→0.

## Timing
- Moore outputs decoded from state (plus opcode/funct/zero/ready); no output registers.
- Reset: state FETCH, `retired`=0, `halted`=0; hence `imem_req`=1, all other outputs 0.
- Latency at zero wait: J 2, BNE/JAL/JR 3, ALU ops/SW 4, LW 5 cycles. Each memory wait cycle adds one.
- `write_pc` high exactly one cycle per instruction, always last; `is_branch`, `is_jump`, `pc_from_reg` mutually exclusive, only with `write_pc`.
- `dmem_read`/`dmem_write` never both high; held steady while waiting.
- `ready` inputs ignored outside their wait states.
- Reset mid-instruction: FETCH next edge, no partial write completes.

## Structure
- Package `cpu_defs`: opcode, funct and ALU-op localparams, state encoding, `reg_dst`/`wb_sel` codes; shared with the datapath.
- Sub-module `ctrl_decode`: combinational opcode/funct → instruction class and `alu_op`; FSM consumes its class.

## Test plan
- Reset, `imem_ready`=1, ADD (0x00/0x20): `ir_write` cycle 1, ALUWB cycle 4 with `reg_write`=1, `reg_dst`=1, `write_pc`=1; `retired`=1.
- LW with `dmem_ready` low 2 cycles: `dmem_read` held 3 cycles, `write_pc` in cycle 7, `wb_sel`=1.
- BNE with `zero`=0 then `zero`=1: `is_branch`=1 then 0, both with `write_pc` in cycle 3.
- JAL then J: LINK shows `reg_dst`=2, `wb_sel`=2, `is_jump`=1; J retires in 2 cycles; `retired`=2.
- Opcode 0x3F: TRAP, `halted`=1, `imem_req`=0 for 10 cycles; `reset` clears and refetches.
- `reset` asserted during MEMWR wait: `dmem_write` drops immediately, `retired` unchanged at 0.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared encodings for the MIPS-subset CPU: opcodes, funct codes, ALU ops,
// control FSM states, instruction classes and writeback selector codes.
package cpu_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_XOR = 2'd2;
  localparam logic [1:0] ALU_SLT = 2'd3;

  localparam logic [1:0] REGDST_RT  = 2'd0;
  localparam logic [1:0] REGDST_RD  = 2'd1;
  localparam logic [1:0] REGDST_R31 = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_EXEC    = 4'd2,
    ST_ALUWB   = 4'd3,
    ST_MEMADDR = 4'd4,
    ST_MEMRD   = 4'd5,
    ST_MEMWB   = 4'd6,
    ST_MEMWR   = 4'd7,
    ST_BRANCH  = 4'd8,
    ST_LINK    = 4'd9,
    ST_JREG    = 4'd10,
    ST_TRAP    = 4'd11
  } state_t;

  typedef enum logic [3:0] {
    CL_ILL   = 4'd0,
    CL_J     = 4'd1,
    CL_JAL   = 4'd2,
    CL_BNE   = 4'd3,
    CL_LW    = 4'd4,
    CL_SW    = 4'd5,
    CL_ALU_R = 4'd6,
    CL_ALU_I = 4'd7,
    CL_JR    = 4'd8
  } iclass_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: opcode/funct to instruction class
// and the ALU operation the execute step should request.
module ctrl_decode
  import cpu_defs::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output iclass_t    iclass_o,
  output logic [1:0] alu_op_o
);

  always_comb begin
    iclass_o = CL_ILL;
    alu_op_o = ALU_ADD;
    case (opcode_i)
      OP_J:    iclass_o = CL_J;
      OP_JAL:  iclass_o = CL_JAL;
      OP_BNE: begin
        iclass_o = CL_BNE;
        alu_op_o = ALU_SUB;
      end
      OP_LW:   iclass_o = CL_LW;
      OP_SW:   iclass_o = CL_SW;
      OP_ADDI: iclass_o = CL_ALU_I;
      OP_XORI: begin
        iclass_o = CL_ALU_I;
        alu_op_o = ALU_XOR;
      end
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD: iclass_o = CL_ALU_R;
          FN_SUB: begin
            iclass_o = CL_ALU_R;
            alu_op_o = ALU_SUB;
          end
          FN_SLT: begin
            iclass_o = CL_ALU_R;
            alu_op_o = ALU_SLT;
          end
          FN_JR:   iclass_o = CL_JR;
          default: iclass_o = CL_ILL;
        endcase
      end
      default: iclass_o = CL_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control FSM: sequences fetch, decode, execute, memory and
// writeback steps and drives every datapath enable from the current state.
module mc_ctrl
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic        write_pc,
  output logic        is_branch,
  output logic        is_jump,
  output logic        pc_from_reg,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_sel,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic        halted,
  output logic [31:0] retired
);

  state_t      state_q, state_d;
  logic [31:0] retired_q, retired_d;
  iclass_t     iclass;
  logic [1:0]  dec_alu_op;

  ctrl_decode u_decode (
    .opcode_i (opcode),
    .funct_i  (funct),
    .iclass_o (iclass),
    .alu_op_o (dec_alu_op)
  );

  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    ir_write    = 1'b0;
    write_pc    = 1'b0;
    is_branch   = 1'b0;
    is_jump     = 1'b0;
    pc_from_reg = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = REGDST_RT;
    wb_sel      = WB_ALU;
    alu_src     = 1'b0;
    alu_op      = ALU_ADD;
    dmem_read   = 1'b0;
    dmem_write  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (iclass)
          CL_J: begin
            write_pc = 1'b1;
            is_jump  = 1'b1;
            state_d  = ST_FETCH;
          end
          CL_JAL:            state_d = ST_LINK;
          CL_BNE:            state_d = ST_BRANCH;
          CL_LW, CL_SW:      state_d = ST_MEMADDR;
          CL_ALU_R, CL_ALU_I: state_d = ST_EXEC;
          CL_JR:             state_d = ST_JREG;
          default:           state_d = ST_TRAP;
        endcase
      end
      ST_EXEC: begin
        alu_src = (iclass == CL_ALU_I);
        alu_op  = dec_alu_op;
        state_d = ST_ALUWB;
      end
      ST_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = (iclass == CL_ALU_R) ? REGDST_RD : REGDST_RT;
        wb_sel    = WB_ALU;
        write_pc  = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_MEMADDR: begin
        alu_src = 1'b1;
        alu_op  = ALU_ADD;
        state_d = (iclass == CL_LW) ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        dmem_read = 1'b1;
        if (dmem_ready) state_d = ST_MEMWB;
      end
      ST_MEMWB: begin
        reg_write = 1'b1;
        reg_dst   = REGDST_RT;
        wb_sel    = WB_MEM;
        write_pc  = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_MEMWR: begin
        dmem_write = 1'b1;
        if (dmem_ready) begin
          write_pc = 1'b1;
          state_d  = ST_FETCH;
        end
      end
      ST_BRANCH: begin
        alu_op    = ALU_SUB;
        write_pc  = 1'b1;
        is_branch = ~zero;
        state_d   = ST_FETCH;
      end
      ST_LINK: begin
        reg_write = 1'b1;
        reg_dst   = REGDST_R31;
        wb_sel    = WB_PC4;
        write_pc  = 1'b1;
        is_jump   = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_JREG: begin
        write_pc    = 1'b1;
        pc_from_reg = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  // Every retirement is marked by exactly one write_pc cycle.
  assign retired_d = write_pc ? retired_q + 32'd1 : retired_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign halted  = (state_q == ST_TRAP);
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: table of instructions with expected
// latency and retire-cycle strobes, plus trap and mid-instruction reset cases.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = 6'h00;
  logic [5:0]  funct = 6'h20;
  logic        zero = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, ir_write, write_pc, is_branch, is_jump, pc_from_reg;
  logic        reg_write, alu_src, dmem_read, dmem_write, halted;
  logic [1:0]  reg_dst, wb_sel, alu_op;
  logic [31:0] retired;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .ir_write(ir_write), .write_pc(write_pc), .is_branch(is_branch),
    .is_jump(is_jump), .pc_from_reg(pc_from_reg), .reg_write(reg_write),
    .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_src(alu_src), .alu_op(alu_op),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .halted(halted),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [5:0] opc;
    logic [5:0] fn;
    logic       z;
    int         iw;
    int         dw;
    int         lat;
    logic       rw;
    logic [1:0] rd;
    logic [1:0] wb;
    logic       br;
    logic       jp;
    logic       pr;
    int         nrd;
    int         nwr;
    logic       chk_alu;
    logic [1:0] aop;
    logic       asrc;
  } vec_t;

  typedef struct {
    string      name;
    int         lat;
    logic       rw;
    logic [1:0] rd;
    logic [1:0] wb;
    logic       br;
    logic       jp;
    logic       pr;
  } exp_t;

  vec_t  vecs[14];
  exp_t  sb[$];
  int    total = 0;
  int    bad = 0;
  int    model_retired = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Entry: posedge+1 with the DUT in FETCH. Exit: posedge+1 after retirement.
  task automatic run_instr(input vec_t v);
    exp_t e;
    exp_t got;
    int   n = 0;
    int   ir_cyc = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    bit   done = 0;
    e.name = v.name; e.lat = v.lat + v.iw + v.dw; e.rw = v.rw; e.rd = v.rd;
    e.wb = v.wb; e.br = v.br; e.jp = v.jp; e.pr = v.pr;
    sb.push_back(e);
    opcode = v.opc;
    funct  = v.fn;
    zero   = v.z;
    while (!done && n < 40) begin
      n++;
      imem_ready = (n > v.iw);
      dmem_ready = ((rd_cnt + wr_cnt) >= v.dw);
      @(negedge clk);
      if (ir_write && ir_cyc == 0) ir_cyc = n;
      if (dmem_read) rd_cnt++;
      if (dmem_write) wr_cnt++;
      chk({v.name, " rd_wr_excl"}, {31'd0, dmem_read & dmem_write}, 32'd0);
      chk({v.name, " pc_sel_excl"},
          {30'd0, 2'(is_branch + is_jump + pc_from_reg) > 2'd1 ||
                  ((is_branch | is_jump | pc_from_reg) & ~write_pc)}, 32'd0);
      if (v.chk_alu && n == v.iw + 3) begin
        chk({v.name, " alu_op"}, {30'd0, alu_op}, {30'd0, v.aop});
        chk({v.name, " alu_src"}, {31'd0, alu_src}, {31'd0, v.asrc});
      end
      if (write_pc) begin
        done = 1;
        if (sb.size() == 0) begin
          chk({v.name, " scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
          got = sb.pop_front();
          chk({got.name, " latency"}, n, got.lat);
          chk({got.name, " is_branch"}, {31'd0, is_branch}, {31'd0, got.br});
          chk({got.name, " is_jump"}, {31'd0, is_jump}, {31'd0, got.jp});
          chk({got.name, " pc_from_reg"}, {31'd0, pc_from_reg}, {31'd0, got.pr});
          chk({got.name, " reg_write"}, {31'd0, reg_write}, {31'd0, got.rw});
          if (got.rw) begin
            chk({got.name, " reg_dst"}, {30'd0, reg_dst}, {30'd0, got.rd});
            chk({got.name, " wb_sel"}, {30'd0, wb_sel}, {30'd0, got.wb});
          end
        end
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk({v.name, " retire_timeout"}, 32'd0, 32'd1);
    else model_retired++;
    chk({v.name, " ir_write_cycle"}, ir_cyc, v.iw + 1);
    chk({v.name, " dmem_read_cycles"}, rd_cnt, v.nrd);
    chk({v.name, " dmem_write_cycles"}, wr_cnt, v.nwr);
    chk({v.name, " retired"}, retired, model_retired);
    $display("instr %-8s opc=%02h fn=%02h cycles=%0d retired=%0d", v.name, v.opc, v.fn, n, retired);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t add_v;
    //          name    opc    fn     z  iw dw lat rw rd wb br jp pr nrd nwr chk aop asrc
    vecs[0]  = '{"ADD",   6'h00, 6'h20, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[1]  = '{"SUB",   6'h00, 6'h22, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    vecs[2]  = '{"SLT",   6'h00, 6'h2A, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 1, 3, 0};
    vecs[3]  = '{"ADDI",  6'h08, 6'h15, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
    vecs[4]  = '{"XORI",  6'h0E, 6'h3F, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1};
    vecs[5]  = '{"LW_W2", 6'h23, 6'h00, 0, 0, 2, 5, 1, 0, 1, 0, 0, 0, 3, 0, 1, 0, 1};
    vecs[6]  = '{"SW_W1", 6'h2B, 6'h00, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 1};
    vecs[7]  = '{"BNE_Z0",6'h05, 6'h00, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0};
    vecs[8]  = '{"BNE_Z1",6'h05, 6'h00, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    vecs[9]  = '{"JAL",   6'h03, 6'h00, 0, 0, 0, 3, 1, 2, 2, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[10] = '{"J",     6'h02, 6'h00, 0, 0, 0, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[11] = '{"JR",    6'h00, 6'h08, 0, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    vecs[12] = '{"ADD_I2",6'h00, 6'h20, 0, 2, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[13] = '{"LW",    6'h23, 6'h00, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst imem_req", {31'd0, imem_req}, 32'd1);
    chk("rst strobes", {20'd0, ir_write, write_pc, is_branch, is_jump, pc_from_reg,
                        reg_write, alu_src, dmem_read, dmem_write, halted, 2'b00}, 32'd0);
    chk("rst codes", {26'd0, reg_dst, wb_sel, alu_op}, 32'd0);
    chk("rst retired", retired, 32'd0);

    // Reset during a stalled store: the write strobe drops without retiring.
    reset = 1'b0;
    opcode = 6'h2B; funct = 6'h00; imem_ready = 1'b1; dmem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("swrst dmem_write_wait", {31'd0, dmem_write}, 32'd1);
    chk("swrst no_write_pc", {31'd0, write_pc}, 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("swrst dmem_write_drop", {31'd0, dmem_write}, 32'd0);
    chk("swrst write_pc", {31'd0, write_pc}, 32'd0);
    chk("swrst imem_req", {31'd0, imem_req}, 32'd1);
    chk("swrst retired", retired, 32'd0);
    $display("instr SW_RST   reset during MEMWR wait retired=%0d", retired);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 14; i++) run_instr(vecs[i]);

    // Illegal opcode traps until reset.
    opcode = 6'h3F; funct = 6'h00; imem_ready = 1'b1;
    @(negedge clk);
    chk("trap ir_write", {31'd0, ir_write}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("trap decode write_pc", {31'd0, write_pc}, 32'd0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("trap halted", {31'd0, halted}, 32'd1);
      chk("trap imem_req", {31'd0, imem_req}, 32'd0);
      chk("trap strobes", {29'd0, write_pc, reg_write, dmem_read | dmem_write}, 32'd0);
    end
    chk("trap retired", retired, model_retired);
    $display("instr TRAP     opc=3f halted=%0d retired=%0d", halted, retired);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("trap_rst halted", {31'd0, halted}, 32'd0);
    chk("trap_rst imem_req", {31'd0, imem_req}, 32'd1);
    chk("trap_rst retired", retired, 32'd0);
    model_retired = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    add_v = vecs[0];
    add_v.name = "ADD_RF";
    run_instr(add_v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
